// File: rtl/rsa_decryption.sv
// RSA decryption core: computes ciphertext^d mod N by left-to-right square-and-always-multiply
// on a bit-serial interleaved modular multiplier, so latency never depends on the key.
module rsa_decryption #(
    parameter int unsigned W = 128
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   ciphertext,
    input  logic [2*W-1:0] private_key,
    output logic [W-1:0]   plaintext,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int unsigned KW = (W > 1) ? $clog2(W) : 1;
    localparam logic [KW-1:0] TopBit = KW'(W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSqr,
        StMul,
        StFinish
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  n_q, n_d;
    logic [W-1:0]  d_q, d_d;
    logic [W-1:0]  c_q, c_d;
    logic [W-1:0]  r_q, r_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] j_q, j_d;
    logic          err_pend_q, err_pend_d;
    logic [W-1:0]  plaintext_q, plaintext_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [W-1:0]  n_in;
    logic [W-1:0]  d_in;
    logic          invalid_in;

    assign n_in       = private_key[2*W-1:W];
    assign d_in       = private_key[W-1:0];
    assign invalid_in = (n_in[W-1:1] == '0) || (ciphertext >= n_in);

    // One interleaved step: acc <- 2*acc + bit*B mod N, each half with a single
    // conditional subtraction. R is the scanned operand for both products.
    logic [W:0]   dbl;
    logic [W-1:0] dbl_red;
    logic [W-1:0] mul_b;
    logic         mul_bit;
    logic [W:0]   sum;
    logic [W-1:0] step_res;

    always_comb begin
        mul_b    = (state_q == StSqr) ? r_q : c_q;
        mul_bit  = r_q[j_q];
        dbl      = {acc_q, 1'b0};
        dbl_red  = (dbl >= {1'b0, n_q}) ? (dbl[W-1:0] - n_q) : dbl[W-1:0];
        sum      = {1'b0, dbl_red} + (mul_bit ? {1'b0, mul_b} : '0);
        step_res = (sum >= {1'b0, n_q}) ? (sum[W-1:0] - n_q) : sum[W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        d_d         = d_q;
        c_d         = c_q;
        r_d         = r_q;
        acc_d       = acc_q;
        k_d         = k_q;
        j_d         = j_q;
        err_pend_d  = err_pend_q;
        plaintext_d = plaintext_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (start) begin
                    n_d         = n_in;
                    d_d         = d_in;
                    c_d         = ciphertext;
                    r_d         = W'(1);
                    acc_d       = '0;
                    k_d         = TopBit;
                    j_d         = TopBit;
                    plaintext_d = '0;
                    err_d       = 1'b0;
                    busy_d      = 1'b1;
                    err_pend_d  = invalid_in;
                    state_d     = invalid_in ? StFinish : StSqr;
                end
            end
            StSqr: begin
                acc_d = step_res;
                if (j_q == '0) begin
                    r_d     = step_res;
                    acc_d   = '0;
                    j_d     = TopBit;
                    state_d = StMul;
                end else begin
                    j_d = j_q - KW'(1);
                end
            end
            StMul: begin
                acc_d = step_res;
                if (j_q == '0) begin
                    // Product is always computed; only its commit depends on the key bit.
                    if (d_q[k_q]) begin
                        r_d = step_res;
                    end
                    acc_d = '0;
                    j_d   = TopBit;
                    if (k_q == '0) begin
                        state_d = StFinish;
                    end else begin
                        k_d     = k_q - KW'(1);
                        state_d = StSqr;
                    end
                end else begin
                    j_d = j_q - KW'(1);
                end
            end
            StFinish: begin
                done_d      = 1'b1;
                plaintext_d = err_pend_q ? '0 : r_q;
                err_d       = err_pend_q;
                n_d         = '0;
                d_d         = '0;
                c_d         = '0;
                r_d         = '0;
                acc_d       = '0;
                k_d         = '0;
                j_d         = '0;
                err_pend_d  = 1'b0;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            n_q         <= '0;
            d_q         <= '0;
            c_q         <= '0;
            r_q         <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            j_q         <= '0;
            err_pend_q  <= 1'b0;
            plaintext_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            d_q         <= d_d;
            c_q         <= c_d;
            r_q         <= r_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            j_q         <= j_d;
            err_pend_q  <= err_pend_d;
            plaintext_q <= plaintext_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign plaintext = plaintext_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rsa_decryption.sv
// Directed bench for rsa_decryption at W=8: vector table plus collision, reset-abort and
// back-to-back sequences. Cycle 1 is the cycle right after the accept edge.
module tb_rsa_decryption;

    localparam int W     = 8;
    localparam int LIMIT = 400;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   ciphertext = '0;
    logic [15:0]  private_key = '0;
    logic [7:0]   plaintext;
    logic         busy;
    logic         done;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;

    rsa_decryption #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ciphertext  (ciphertext),
        .private_key (private_key),
        .plaintext   (plaintext),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request, optionally re-pulse start at cycle collide_at, and return at the
    // done cycle (or after LIMIT cycles). leak flags any nonzero output before done.
    task automatic run_op(input logic [7:0] n, input logic [7:0] d, input logic [7:0] c,
                          input int collide_at, output int lat, output logic leak);
        @(negedge clk);
        private_key = {n, d};
        ciphertext  = c;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        private_key = 16'hFFFF;
        ciphertext  = 8'hAA;
        lat  = 1;
        leak = 1'b0;
        while (done !== 1'b1 && lat < LIMIT) begin
            if (plaintext !== 8'h00 || busy !== 1'b1 || err !== 1'b0) leak = 1'b1;
            if (collide_at != 0 && lat == collide_at) begin
                start       = 1'b1;
                private_key = 16'hFF01;
                ciphertext  = 8'h05;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    typedef struct {
        string      name;
        logic [7:0] n;
        logic [7:0] d;
        logic [7:0] c;
        logic [7:0] pt;
        logic       e;
        int         lat;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int   lat;
        logic leak;
        int   ndone;
        int   g;

        vecs[0]  = '{"nominal",   8'd143, 8'd103, 8'h30, 8'h09, 1'b0, 130};
        vecs[1]  = '{"d_one",     8'd143, 8'h01,  8'h30, 8'h30, 1'b0, 130};
        vecs[2]  = '{"d_ff",      8'd143, 8'hFF,  8'h30, 8'h01, 1'b0, 130};
        vecs[3]  = '{"d_zero",    8'd143, 8'h00,  8'h30, 8'h01, 1'b0, 130};
        vecs[4]  = '{"n_one",     8'd1,   8'd103, 8'h00, 8'h00, 1'b1, 2};
        vecs[5]  = '{"c_ge_n",    8'd143, 8'd103, 8'h90, 8'h00, 1'b1, 2};
        vecs[6]  = '{"c_eq_n",    8'd143, 8'd103, 8'h8F, 8'h00, 1'b1, 2};
        vecs[7]  = '{"n_zero",    8'd0,   8'd5,   8'h00, 8'h00, 1'b1, 2};
        vecs[8]  = '{"c_zero",    8'd143, 8'd103, 8'h00, 8'h00, 1'b0, 130};
        vecs[9]  = '{"n255_pow8", 8'd255, 8'd8,   8'h02, 8'h01, 1'b0, 130};
        vecs[10] = '{"n255_neg1", 8'd255, 8'd3,   8'hFE, 8'hFE, 1'b0, 130};
        vecs[11] = '{"n200_3p5",  8'd200, 8'd5,   8'h03, 8'h2B, 1'b0, 130};
        vecs[12] = '{"n2_c1",     8'd2,   8'hFF,  8'h01, 8'h01, 1'b0, 130};

        repeat (3) @(negedge clk);
        check("reset_outputs", {plaintext, busy, done, err}, 32'h0);
        check("reset_regs", {dut.n_q, dut.d_q, dut.c_q, dut.r_q}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].n, vecs[i].d, vecs[i].c, 0, lat, leak);
            check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
            check({vecs[i].name, "_plaintext"}, plaintext, vecs[i].pt);
            check({vecs[i].name, "_err"}, err, vecs[i].e);
            check({vecs[i].name, "_busy_at_done"}, busy, 1);
            check({vecs[i].name, "_no_leak"}, leak, 0);
            check({vecs[i].name, "_zeroized"}, {dut.n_q, dut.d_q, dut.c_q, dut.r_q}, 32'h0);
            @(negedge clk);
            check({vecs[i].name, "_after"}, {done, busy}, 0);
            check({vecs[i].name, "_hold"}, {plaintext, err}, {vecs[i].pt, vecs[i].e});
        end

        // start pulse while busy must not disturb the running op or trigger a second one
        run_op(8'd143, 8'd103, 8'h30, 50, lat, leak);
        check("collide_latency", lat, 130);
        check("collide_plaintext", plaintext, 8'h09);
        check("collide_no_leak", leak, 0);
        ndone = 0;
        repeat (200) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("collide_no_second_done", ndone, 0);

        // reset at cycle 60 aborts immediately with no done pulse
        @(negedge clk);
        private_key = {8'd143, 8'd103};
        ciphertext  = 8'h30;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (59) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {plaintext, busy, done, err}, 32'h0);
        check("rst_mid_regs", {dut.n_q, dut.d_q, dut.c_q, dut.r_q}, 32'h0);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        rst_n = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        check("rst_mid_no_done", ndone, 0);
        run_op(8'd143, 8'd103, 8'h30, 0, lat, leak);
        check("rst_after_latency", lat, 130);
        check("rst_after_plaintext", plaintext, 8'h09);

        // start held high: second request accepted on the edge after the done edge
        @(negedge clk);
        private_key = {8'd143, 8'd1};
        ciphertext  = 8'h30;
        start       = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done !== 1'b1 && lat < LIMIT);
        check("b2b_first_latency", lat, 130);
        check("b2b_first_plaintext", plaintext, 8'h30);
        private_key = {8'd143, 8'd103};
        g = 0;
        do begin
            @(negedge clk);
            g++;
            if (g == 1) check("b2b_cleared", {plaintext, busy, done, err}, 32'h4);
        end while (done !== 1'b1 && g < LIMIT);
        start = 1'b0;
        check("b2b_second_latency", g, 130);
        check("b2b_second_plaintext", plaintext, 8'h09);
        @(negedge clk);
        @(negedge clk);
        check("b2b_idle", {done, busy}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rsa_decryption.md
RSA_DECRYPTION -- requirements
Module: rsa_decryption

Interface
REQ-001 Parameter: W, default 128, operand width in bits (ciphertext, modulus, exponent, plaintext).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset; the block has one clock, and this reset is asynchronous and active-low.
REQ-004 Port: start  input  1  level request; sampled only in IDLE.
REQ-005 Port: ciphertext  input  W  value to decrypt; sampled with start.
REQ-006 Port: private_key  input  2W  {modulus N [2W-1:W], private exponent d [W-1:0]}; sampled with start.
REQ-007 Port: plaintext  output  W  result C^d mod N.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  one-cycle completion pulse.
REQ-010 Port: err  output  1  invalid-operand flag, valid with done.

Function
REQ-011 The FSM SHALL have the states IDLE, SQR, MUL and FINISH, with all outputs registered.
REQ-012 In IDLE with start=1, the block SHALL capture ciphertext, N and d into internal registers on that edge (the accept edge).
REQ-013 If N<2 or ciphertext>=N at accept, the block SHALL go to FINISH with err pending and skip the arithmetic.
REQ-014 Otherwise, at accept: R=1, bit index k=W-1, next state SQR.
REQ-015 Modular multiply SHALL be bit-serial interleaved: one operand bit per cycle, MSB first, R'=2R mod N, then +B mod N if the bit is set, each step using at most one conditional subtraction; exactly W cycles per product.
REQ-016 SQR SHALL compute R*R mod N in W cycles, then go to MUL.
REQ-017 MUL SHALL compute R*C mod N in W cycles unconditionally; at its end, R takes the product if d[k]=1, otherwise R is unchanged.
REQ-018 After MUL: if k==0, go to FINISH; else decrement k and go to SQR.
REQ-019 Total latency from the accept edge to done high SHALL be exactly 2*W*W+2 cycles for every valid input, independent of the value and Hamming weight of d (constant time, no early exit).
REQ-020 For an invalid input, done SHALL go high exactly 2 cycles after the accept edge.
REQ-021 FINISH SHALL, for one cycle: set done=1; set plaintext=R (or 0 if err); set err; zeroize the captured N, d, C and R; then return to IDLE.
REQ-022 busy SHALL be high from the cycle after the accept edge through the cycle done is high.
REQ-023 start while busy SHALL be ignored, with no effect on the operation in progress.
REQ-024 start held high in IDLE on the same edge FINISH exits SHALL be accepted only on the next edge, while in IDLE.
REQ-025 plaintext SHALL hold 0 while busy and SHALL never expose intermediate R values.
REQ-026 plaintext and err SHALL hold their FINISH values until the next accept, at which point both clear to 0.
REQ-027 Exponent d=0 SHALL yield plaintext=1 (for N>=2); d=1 SHALL yield plaintext=ciphertext.

Reset
REQ-028 While rst_n=0, regardless of clk: state=IDLE, plaintext=0, done=0, err=0, busy=0, and all key, operand and accumulator registers 0.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-030 The first accept after reset deassertion SHALL behave as from power-up.

Verification (W=8)
REQ-031 Nominal: private_key=16'h8F67 (N=143, d=103), ciphertext=8'h30, start 1 cycle -> done exactly 130 cycles after accept, plaintext=8'h09, err=0.
REQ-032 Constant time: d=8'h01 and d=8'hFF with N=143, C=8'h30 -> both done at exactly 130 cycles; d=1 gives plaintext=8'h30.
REQ-033 Invalid operands: N=8'h01, or ciphertext=8'h90 with N=143 -> done 2 cycles after accept, err=1, plaintext=0.
REQ-034 Busy collision: start re-pulsed at cycle 50 with other operands -> ignored; original result 8'h09 at cycle 130, no second done.
REQ-035 Reset mid-op: rst_n low at cycle 60 -> outputs 0 immediately, no done; a new nominal request after release gives 8'h09 at 130 cycles.
REQ-036 d=8'h00 with N=143, C=8'h30 -> plaintext=8'h01 at 130 cycles; internal key registers read 0 after done.
